alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Issue/capture controller that sits in front of the combinational ALU: it accepts an instruction with its register operands, decodes it into the ALU function code and operand pair, holds them stable until the ALU's `cache_done` qualifier fires, then registers the ALU's result and zero flag and returns them on a valid/ready response port. It is the driving and consuming end of the ALU's `input1w`/`input2w`/`funcw`/`inst` → `out`/`zero` interface. A timeout counter guards against a `cache_done` that never arrives.

## Interface
- TIMEOUT_CYCLES, 64: maximum number of EXEC cycles to wait for `cache_done`; 0 disables the timeout.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_b  in  1  synchronous, active-high reset: asserted = 1, sampled on the `clk` rising edge.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_inst  in  32  MIPS instruction word.
- req_rs_val  in  32  rs register value.
- req_rt_val  in  32  rt register value.
- alu_in1  out  32  ALU operand 1.
- alu_in2  out  32  ALU operand 2.
- alu_func  out  6  ALU function code.
- alu_inst  out  32  instruction forwarded to the ALU, which takes the shift amount from `[10:6]`.
- cache_done  in  1  ALU evaluation qualifier.
- alu_out  in  32  ALU result.
- alu_zero  in  1  ALU branch-condition flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  32  captured result.
- rsp_zero  out  1  captured branch condition.
- rsp_is_branch  out  1  the instruction was BEQ, BNE, BLEZ, BGTZ or BGEZ.
- rsp_illegal  out  1  the opcode/funct pair is not supported.
- rsp_timeout  out  1  `cache_done` was not seen within TIMEOUT_CYCLES.

## Operation
- FSM states: IDLE, EXEC, RESP.
  - IDLE: `req_ready`=1. On `req_valid`: register the decode, operands and instruction.
    - Legal instruction: go to EXEC.
    - Illegal instruction: go to RESP with `rsp_illegal`=1, `rsp_result`=0, `rsp_zero`=0.
  - EXEC: `alu_*` are driven from registers and stay stable.
    - On `cache_done`=1: capture `alu_out` and `alu_zero`, then go to RESP.
    - Otherwise, if the wait counter reaches TIMEOUT_CYCLES-1: go to RESP with `rsp_timeout`=1, `rsp_result`=0, `rsp_zero`=0.
  - RESP: `rsp_valid`=1 and all `rsp_*` fields are held. On `rsp_ready`=1: go to IDLE.
- `cache_done` is ignored outside EXEC.
- `req_ready` is 0 in EXEC and RESP. There is no same-cycle turnaround from RESP to a new request.
- R-type decode (opcode 000000):
  - `alu_func` = funct. `alu_in1` = rs, `alu_in2` = rt.
  - Legal funct values: 000000, 000010, 000011, 000100, 000110, 011000, 011010, 100000, 100001, 100010, 100011, 100100, 100101, 100110, 100111, 101010.
- I-type decode. Operand 1 is rs. Operand 2 is the immediate, sign-extended (se) or zero-extended (ze), or rt where stated.
  - ADDI 001000 → func 100000, se.
  - ADDIU 001001 → 100001, se.
  - SLTI 001010 → 101010, se.
  - ANDI 001100 → 100100, ze.
  - ORI 001101 → 100101, ze.
  - XORI 001110 → 100110, ze.
  - LUI 001111 → 111101, ze.
  - BEQ 000100 → 111000, operand 2 = rt.
  - BNE 000101 → 111001, operand 2 = rt.
  - BLEZ 000110 → 111010, operand 2 = 0.
  - BGTZ 000111 → 111011, operand 2 = 0.
  - BGEZ: opcode 000001 with rt=00001 → 111100, operand 2 = 0.
- Any other opcode, or a REGIMM rt other than 00001, is illegal.
- Branch instructions: `rsp_is_branch`=1 and `rsp_result` is forced to 0. All other instructions: `rsp_result` = captured `alu_out`.

## Timing
- Reset values:
  - state = IDLE, `req_ready`=1, `rsp_valid`=0.
  - All `rsp_*` fields are 0.
  - `alu_in1`, `alu_in2`, `alu_func` and `alu_inst` are 0.
  - Wait counter is 0.
- Reset takes effect from any state, including mid-EXEC and mid-RESP; any in-flight request is discarded.
- Latency, counted from the request accept edge to the `rsp_valid` rising edge, is 1 + k cycles. k (≥1) is the EXEC cycle in which `cache_done` is first high.
- If `cache_done` is already high in the first EXEC cycle, `rsp_valid` is 1 exactly 2 edges after accept.
- An illegal instruction gives `rsp_valid`=1 one edge after accept.
- Timeout: with TIMEOUT_CYCLES=N, RESP is entered after exactly N EXEC cycles. The counter clears on every accept.
- `cache_done` arriving in the same cycle the counter hits N-1 wins: the result is captured and `rsp_timeout`=0.
- `alu_*` keep their last values in RESP and IDLE until the next accept.

## Test plan
- ADDU: inst 0x00221821 (rs=1, rt=2, funct 100001), rs=5, rt=7, `cache_done` high the 1st EXEC cycle, ALU returns 12 → `alu_func`=100001; `rsp_result`=12, `rsp_valid` two edges after accept.
- ORI: inst 0x3441FFFF with rs=0x00010000 → `alu_in2`=0x0000FFFF, `alu_func`=100101. LUI: inst 0x3C011234 → `alu_func`=111101, `alu_in2`=0x00001234.
- BEQ: rs=rt=9, ALU `zero`=1, `out`=0xDEAD → `rsp_is_branch`=1, `rsp_zero`=1, `rsp_result`=0. BGEZ: opcode 000001, rt=00001 → `alu_func`=111100.
- Illegal opcode 0x3F → `rsp_illegal`=1, no EXEC cycle, `rsp_valid` one edge after accept. With `rsp_ready` held 0 for 5 cycles, the response is held stable throughout.
- TIMEOUT_CYCLES=4, `cache_done` held 0 → `rsp_timeout`=1 after 4 EXEC cycles. Second run with `cache_done`=1 in EXEC cycle 4 → result captured, `rsp_timeout`=0.
- `rst_b`=1 during EXEC (cycle 2) and again during RESP → next edge gives IDLE, `req_ready`=1, all outputs 0. A new request is accepted normally afterwards.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/capture controller in front of the combinational ALU: decodes a MIPS instruction into
// function code and operands, waits for cache_done (with timeout), and returns the result.
module alu_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_inst,
    input  logic [31:0] req_rs_val,
    input  logic [31:0] req_rt_val,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [5:0]  alu_func,
    output logic [31:0] alu_inst,
    input  logic        cache_done,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_is_branch,
    output logic        rsp_illegal,
    output logic        rsp_timeout
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
    localparam logic [CntW-1:0] CntMax = TimeoutEn ? CntW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     alu_in1_q, alu_in1_d;
    logic [31:0]     alu_in2_q, alu_in2_d;
    logic [5:0]      alu_func_q, alu_func_d;
    logic [31:0]     alu_inst_q, alu_inst_d;
    logic [31:0]     rsp_result_q, rsp_result_d;
    logic            rsp_zero_q, rsp_zero_d;
    logic            rsp_is_branch_q, rsp_is_branch_d;
    logic            rsp_illegal_q, rsp_illegal_d;
    logic            rsp_timeout_q, rsp_timeout_d;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt_field;
    logic [31:0] imm_se;
    logic [31:0] imm_ze;
    logic        dec_legal;
    logic        dec_branch;
    logic [5:0]  dec_func;
    logic [31:0] dec_in2;

    assign opcode   = req_inst[31:26];
    assign funct    = req_inst[5:0];
    assign rt_field = req_inst[20:16];
    assign imm_se   = {{16{req_inst[15]}}, req_inst[15:0]};
    assign imm_ze   = {16'h0000, req_inst[15:0]};

    always_comb begin
        dec_legal  = 1'b1;
        dec_branch = 1'b0;
        dec_func   = 6'b000000;
        dec_in2    = req_rt_val;
        case (opcode)
            6'b000000: begin
                dec_func = funct;
                case (funct)
                    6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b011000,
                    6'b011010, 6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                    6'b100101, 6'b100110, 6'b100111, 6'b101010: dec_legal = 1'b1;
                    default: dec_legal = 1'b0;
                endcase
            end
            6'b001000: begin dec_func = 6'b100000; dec_in2 = imm_se; end
            6'b001001: begin dec_func = 6'b100001; dec_in2 = imm_se; end
            6'b001010: begin dec_func = 6'b101010; dec_in2 = imm_se; end
            6'b001100: begin dec_func = 6'b100100; dec_in2 = imm_ze; end
            6'b001101: begin dec_func = 6'b100101; dec_in2 = imm_ze; end
            6'b001110: begin dec_func = 6'b100110; dec_in2 = imm_ze; end
            6'b001111: begin dec_func = 6'b111101; dec_in2 = imm_ze; end
            6'b000100: begin dec_func = 6'b111000; dec_branch = 1'b1; end
            6'b000101: begin dec_func = 6'b111001; dec_branch = 1'b1; end
            6'b000110: begin dec_func = 6'b111010; dec_in2 = '0; dec_branch = 1'b1; end
            6'b000111: begin dec_func = 6'b111011; dec_in2 = '0; dec_branch = 1'b1; end
            6'b000001: begin
                // REGIMM: only BGEZ (rt = 00001) is supported
                dec_func   = 6'b111100;
                dec_in2    = '0;
                dec_branch = 1'b1;
                dec_legal  = (rt_field == 5'b00001);
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        alu_in1_d       = alu_in1_q;
        alu_in2_d       = alu_in2_q;
        alu_func_d      = alu_func_q;
        alu_inst_d      = alu_inst_q;
        rsp_result_d    = rsp_result_q;
        rsp_zero_d      = rsp_zero_q;
        rsp_is_branch_d = rsp_is_branch_q;
        rsp_illegal_d   = rsp_illegal_q;
        rsp_timeout_d   = rsp_timeout_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    alu_in1_d       = req_rs_val;
                    alu_in2_d       = dec_in2;
                    alu_func_d      = dec_func;
                    alu_inst_d      = req_inst;
                    cnt_d           = '0;
                    rsp_result_d    = '0;
                    rsp_zero_d      = 1'b0;
                    rsp_is_branch_d = dec_branch;
                    rsp_illegal_d   = ~dec_legal;
                    rsp_timeout_d   = 1'b0;
                    state_d         = dec_legal ? StExec : StResp;
                end
            end
            StExec: begin
                // cache_done takes priority over a timeout in the same cycle
                if (cache_done) begin
                    rsp_result_d = rsp_is_branch_q ? 32'h0 : alu_out;
                    rsp_zero_d   = alu_zero;
                    state_d      = StResp;
                end else if (TimeoutEn && (cnt_q == CntMax)) begin
                    rsp_timeout_d = 1'b1;
                    state_d       = StResp;
                end else if (TimeoutEn) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            alu_in1_q       <= '0;
            alu_in2_q       <= '0;
            alu_func_q      <= '0;
            alu_inst_q      <= '0;
            rsp_result_q    <= '0;
            rsp_zero_q      <= 1'b0;
            rsp_is_branch_q <= 1'b0;
            rsp_illegal_q   <= 1'b0;
            rsp_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            alu_in1_q       <= alu_in1_d;
            alu_in2_q       <= alu_in2_d;
            alu_func_q      <= alu_func_d;
            alu_inst_q      <= alu_inst_d;
            rsp_result_q    <= rsp_result_d;
            rsp_zero_q      <= rsp_zero_d;
            rsp_is_branch_q <= rsp_is_branch_d;
            rsp_illegal_q   <= rsp_illegal_d;
            rsp_timeout_q   <= rsp_timeout_d;
        end
    end

    assign req_ready     = (state_q == StIdle);
    assign rsp_valid     = (state_q == StResp);
    assign alu_in1       = alu_in1_q;
    assign alu_in2       = alu_in2_q;
    assign alu_func      = alu_func_q;
    assign alu_inst      = alu_inst_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_zero      = rsp_zero_q;
    assign rsp_is_branch = rsp_is_branch_q;
    assign rsp_illegal   = rsp_illegal_q;
    assign rsp_timeout   = rsp_timeout_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: the bench plays the ALU and a scoreboard of expected
// responses is filled on accept and drained when the response is consumed.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_inst;
    logic [31:0] req_rs_val;
    logic [31:0] req_rt_val;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [5:0]  alu_func;
    logic [31:0] alu_inst;
    logic        cache_done;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_is_branch;
    logic        rsp_illegal;
    logic        rsp_timeout;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        branch;
        logic        illegal;
        logic        timeout;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [5:0]  func;
        logic [31:0] in2;
        int          cd;
        logic [31:0] out;
        logic        zin;
        int          lat;
        int          hold;
        exp_t        exp;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   fails  = 0;

    alu_issue_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_inst     (req_inst),
        .req_rs_val   (req_rs_val),
        .req_rt_val   (req_rt_val),
        .alu_in1      (alu_in1),
        .alu_in2      (alu_in2),
        .alu_func     (alu_func),
        .alu_inst     (alu_inst),
        .cache_done   (cache_done),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_is_branch(rsp_is_branch),
        .rsp_illegal  (rsp_illegal),
        .rsp_timeout  (rsp_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] rs,
                                input logic [31:0] rt, input logic [5:0] func,
                                input logic [31:0] in2, input int cd, input logic [31:0] out,
                                input logic zin, input int lat, input int hold,
                                input logic [31:0] res, input logic zero, input logic br,
                                input logic ill, input logic to);
        vec_t v;
        v.inst = inst; v.rs = rs; v.rt = rt; v.func = func; v.in2 = in2;
        v.cd = cd; v.out = out; v.zin = zin; v.lat = lat; v.hold = hold;
        v.exp.result = res; v.exp.zero = zero; v.exp.branch = br;
        v.exp.illegal = ill; v.exp.timeout = to;
        return v;
    endfunction

    task automatic check_cleared(input string tag);
        check_eq({tag, "_req_ready"}, req_ready, 1);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
        check_eq({tag, "_rsp_result"}, rsp_result, 0);
        check_eq({tag, "_rsp_zero"}, rsp_zero, 0);
        check_eq({tag, "_rsp_branch"}, rsp_is_branch, 0);
        check_eq({tag, "_rsp_illegal"}, rsp_illegal, 0);
        check_eq({tag, "_rsp_timeout"}, rsp_timeout, 0);
        check_eq({tag, "_alu_in1"}, alu_in1, 0);
        check_eq({tag, "_alu_in2"}, alu_in2, 0);
        check_eq({tag, "_alu_func"}, alu_func, 0);
        check_eq({tag, "_alu_inst"}, alu_inst, 0);
    endtask

    task automatic do_reset();
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        sb_q.delete();
    endtask

    // Issue one request and accept the response; starts and ends 1 time unit after a clk edge.
    task automatic run_req(input string tag, input vec_t v);
        int edges;
        int exec;
        exp_t e;
        check_eq({tag, "_req_ready"}, req_ready, 1);
        req_valid = 1'b1; req_inst = v.inst; req_rs_val = v.rs; req_rt_val = v.rt;
        @(posedge clk); #1;
        req_valid = 1'b0; req_inst = $urandom; req_rs_val = $urandom; req_rt_val = $urandom;
        sb_q.push_back(v.exp);
        edges = 1;
        exec  = 0;
        while (!rsp_valid && edges < 20) begin
            exec++;
            if (exec == 1) begin
                check_eq({tag, "_alu_func"}, alu_func, v.func);
                check_eq({tag, "_alu_in1"}, alu_in1, v.rs);
                check_eq({tag, "_alu_in2"}, alu_in2, v.in2);
                check_eq({tag, "_alu_inst"}, alu_inst, v.inst);
            end
            cache_done = (exec == v.cd);
            alu_out    = v.out;
            alu_zero   = v.zin;
            @(posedge clk); #1;
            edges++;
        end
        cache_done = 1'b0;
        check_eq({tag, "_rsp_arrived"}, rsp_valid, 1);
        if (!rsp_valid) begin
            do_reset();
            return;
        end
        check_eq({tag, "_latency"}, edges, v.lat);
        for (int i = 0; i < v.hold; i++) begin
            cache_done = 1'b1;
            alu_out    = 32'hBAD0BAD0;
            @(posedge clk); #1;
            check_eq({tag, "_hold_valid"}, rsp_valid, 1);
            check_eq({tag, "_hold_result"}, rsp_result, sb_q[0].result);
            check_eq({tag, "_hold_illegal"}, rsp_illegal, sb_q[0].illegal);
            check_eq({tag, "_hold_timeout"}, rsp_timeout, sb_q[0].timeout);
        end
        cache_done = 1'b0;
        if (!v.exp.illegal) begin
            check_eq({tag, "_alu_func_kept"}, alu_func, v.func);
        end
        e = sb_q.pop_front();
        check_eq({tag, "_result"}, rsp_result, e.result);
        check_eq({tag, "_zero"}, rsp_zero, e.zero);
        check_eq({tag, "_branch"}, rsp_is_branch, e.branch);
        check_eq({tag, "_illegal"}, rsp_illegal, e.illegal);
        check_eq({tag, "_timeout"}, rsp_timeout, e.timeout);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_eq({tag, "_rsp_dropped"}, rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_b = 1'b1; req_valid = 1'b0; req_inst = '0; req_rs_val = '0; req_rt_val = '0;
        cache_done = 1'b0; alu_out = '0; alu_zero = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b0;
        check_cleared("reset");

        run_req("addu", mk(32'h00221821, 32'd5, 32'd7, 6'b100001, 32'd7, 1, 32'd12, 1'b0,
                           2, 0, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0));
        run_req("ori", mk(32'h3441FFFF, 32'h00010000, 32'h55, 6'b100101, 32'h0000FFFF, 2,
                          32'h0001FFFF, 1'b0, 3, 0, 32'h0001FFFF, 1'b0, 1'b0, 1'b0, 1'b0));
        run_req("lui", mk(32'h3C011234, 32'h0, 32'h77, 6'b111101, 32'h00001234, 1,
                          32'h12340000, 1'b0, 2, 0, 32'h12340000, 1'b0, 1'b0, 1'b0, 1'b0));
        run_req("addi", mk(32'h2021FFFE, 32'd10, 32'h99, 6'b100000, 32'hFFFFFFFE, 1, 32'd8,
                           1'b0, 2, 0, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0));
        run_req("beq", mk(32'h10220003, 32'd9, 32'd9, 6'b111000, 32'd9, 1, 32'h0000DEAD,
                          1'b1, 2, 0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0));
        run_req("bgez", mk(32'h04210004, 32'hFFFFFFF0, 32'h3, 6'b111100, 32'h0, 3, 32'h1234,
                           1'b0, 4, 0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
        run_req("ill_op", mk(32'hFC000000, 32'h1, 32'h2, 6'b0, 32'h0, 1, 32'hFFFF, 1'b1,
                             1, 5, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0));
        run_req("ill_regimm", mk(32'h04200004, 32'h1, 32'h2, 6'b0, 32'h0, 1, 32'hFFFF, 1'b1,
                                 1, 0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0));
        run_req("ill_funct", mk(32'h00221801, 32'h1, 32'h2, 6'b0, 32'h0, 1, 32'hFFFF, 1'b1,
                                1, 0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0));
        run_req("tmo", mk(32'h00221821, 32'd3, 32'd4, 6'b100001, 32'd4, 0, 32'h77, 1'b1,
                          5, 0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1));
        run_req("tmo_race", mk(32'h00221821, 32'd3, 32'd4, 6'b100001, 32'd4, 4, 32'd7, 1'b0,
                               5, 0, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0));

        // reset in the second EXEC cycle
        req_valid = 1'b1; req_inst = 32'h00221821; req_rs_val = 32'd1; req_rt_val = 32'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("exec2_state", rsp_valid, 0);
        check_eq("exec2_busy", req_ready, 0);
        do_reset();
        check_cleared("rst_exec");

        // reset while a response is pending
        req_valid = 1'b1; req_inst = 32'hFC000000; req_rs_val = 32'd1; req_rt_val = 32'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("resp_pending", rsp_valid, 1);
        do_reset();
        check_cleared("rst_resp");

        run_req("after_rst", mk(32'h00221821, 32'd20, 32'd22, 6'b100001, 32'd22, 1, 32'd42,
                                1'b0, 2, 0, 32'd42, 1'b0, 1'b0, 1'b0, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
